nrs_demapper: RTL and testbench
===============================

Name: nrs_demapper

Overview:
- Sits directly upstream of the channel-estimation control unit, between the FFT/resource-grid output and channel estimation.
- Watches the per-subframe resource-element stream: 12 subcarriers × 14 OFDM symbols.
- Captures the 8 NRS resource elements (antenna port 0) into a ping-pong buffer.
- Serves them to the estimator through the col / nrs_index_addr / demap_read / demap_ready / est_ack_demap handshake.

Parameters:
- DW, 16, bit width of each of the real and imaginary parts of a resource element.
- NSC, 12, subcarriers per OFDM symbol.
- NSYM, 14, OFDM symbols per subframe.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- sof  in  1  start of subframe; coincides with the first in_valid of a subframe.
- in_valid  in  1  resource element present on in_re/in_im.
- in_re  in  DW  real part, signed.
- in_im  in  DW  imaginary part, signed.
- v_shift  in  3  cell shift 0..5; sampled on sof.
- col  in  4  symbol to read: 5, 6, 12 or 13.
- nrs_index_addr  in  2  bit0 = pilot m within the symbol; bit1 ignored.
- demap_read  in  1  read strobe.
- est_ack_demap  in  1  estimator done with the current read bank; 1-cycle pulse.
- demap_ready  out  1  a full bank is available for reading.
- rd_re  out  DW  pilot real part, registered.
- rd_im  out  DW  pilot imaginary part, registered.
- rd_valid  out  1  rd_re/rd_im valid.
- overflow  out  1  sticky: a subframe was dropped.

Behaviour:
Reset:
- All outputs are 0.
- Both banks are EMPTY; write and read pointers are at bank 0; counters are 0.
- Write FSM is in WAIT_SOF.
- Reset mid-operation discards all captured data.

Write FSM (WAIT_SOF, CAPTURE, DROP):
- WAIT_SOF: on sof & in_valid, latch v_shift.
  - If the write bank is EMPTY, go to CAPTURE.
  - Otherwise go to DROP and set overflow.
  - The sof sample itself is processed as (symbol 0, subcarrier 0).
- Counters: sc advances 0..NSC-1 on each in_valid; on wrap, sym advances 0..NSYM-1. Cycles with in_valid low hold both counters.
- Pilot condition: sym ∈ {5, 6, 12, 13} and sc == 6m + ((v + v_shift_latched) mod 6), with m ∈ {0, 1}.
  - v = 0 for symbols 5 and 12.
  - v = 3 for symbols 6 and 13.
- Pilot storage address: {sym-slot[1:0], m}, where sym-slot is 5→0, 6→1, 12→2, 13→3.
- On the last sample (sym 13, sc 11):
  - the write bank becomes FULL;
  - the write pointer toggles;
  - the FSM returns to WAIT_SOF.
- demap_ready rises on the next cycle.
- DROP: count samples without writing; return to WAIT_SOF after the last sample.
- sof asserted while in CAPTURE or DROP means early restart: partial data is discarded, counters restart at (0, 0) with the new v_shift, and the FULL/EMPTY check is re-evaluated.
- In any state, in_valid without sof outside a subframe is ignored.

Read side:
- demap_ready = read bank is FULL.
- demap_read at cycle t with a valid col → rd_re/rd_im/rd_valid at t+1, from the read bank.
- demap_read with an invalid col → rd_valid = 1, data = 0.
- No read strobe → rd_valid = 0; data holds.
- demap_read while demap_ready = 0 → rd_valid = 0.
- est_ack_demap: the read bank becomes EMPTY and the read pointer toggles.
  - demap_ready stays 1 if the other bank is FULL; otherwise it falls the next cycle.
  - est_ack_demap while demap_ready = 0 is ignored.
- Simultaneous bank completion and est_ack_demap on different banks: both actions are taken.
- Simultaneous completion and ack on the same bank cannot occur, because the same bank cannot be both write-FULL and read-acked at once.

Arithmetic: no arithmetic on data; samples are stored verbatim (2·DW bits per entry, 2 banks × 8 entries).

Test Plan:
- Basic capture:
  - Stimulus: v_shift=0; one subframe where sample value = sym*16+sc.
  - Response: demap_ready=1 one cycle after sample 167. Reads return:
    - col5 idx0 → 80, idx1 → 86;
    - col6 → 99, 105;
    - col12 → 192, 198;
    - col13 → 211, 217.
  - Each read arrives 1 cycle after demap_read.
- v_shift sweep:
  - Stimulus: v_shift=4.
  - Response: col5 reads subcarriers 4 and 10; col6 reads subcarriers 1 and 7. Repeat for all values 0..5.
- Ping-pong:
  - Stimulus: two back-to-back subframes with no ack.
  - Response: second bank fills, demap_ready stays 1.
  - After one est_ack_demap: reads return subframe-2 data; demap_ready stays 1.
  - After a second ack: demap_ready falls.
- Overflow:
  - Stimulus: a third subframe arrives with both banks FULL.
  - Response: overflow=1 (sticky); bank contents unchanged.
  - After an ack followed by a fourth subframe: the fourth subframe is captured.
- Early sof:
  - Stimulus: sof at sample 60 of a subframe.
  - Response: capture restarts; no demap_ready until 168 further samples.
  - in_valid gaps of 3 cycles: results identical to gap-free.
- Reset mid-capture:
  - Stimulus: rst pulse during symbol 12.
  - Response: all outputs 0, demap_ready=0, overflow=0. The next full subframe is captured correctly.

Source files
------------

// File: rtl/nrs_demapper.sv
// NRS demapper: captures the 8 antenna-port-0 NRS resource elements of each subframe
// into a ping-pong buffer and serves them to the channel estimator.
module nrs_demapper #(
    parameter int DW   = 16,
    parameter int NSC  = 12,
    parameter int NSYM = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sof,
    input  logic          in_valid,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    input  logic [2:0]    v_shift,
    input  logic [3:0]    col,
    input  logic [1:0]    nrs_index_addr,
    input  logic          demap_read,
    input  logic          est_ack_demap,
    output logic          demap_ready,
    output logic [DW-1:0] rd_re,
    output logic [DW-1:0] rd_im,
    output logic          rd_valid,
    output logic          overflow
);

    localparam int SCW = $clog2(NSC);
    localparam int SYW = $clog2(NSYM);
    localparam logic [SCW-1:0] SC_LAST  = SCW'(NSC - 1);
    localparam logic [SYW-1:0] SYM_LAST = SYW'(NSYM - 1);

    typedef enum logic [1:0] {WAIT_SOF, CAPTURE, DROP} wr_state_t;

    wr_state_t       state, state_nxt;
    logic [SCW-1:0]  sc;
    logic [SYW-1:0]  sym;
    logic [2:0]      vs_lat;
    logic [1:0]      bank_full, bank_full_nxt;
    logic            wr_ptr, rd_ptr;
    logic [2*DW-1:0] mem [16];

    logic            start, step, last_sample, complete, ack_ok;
    logic            is_nrs_sym, v3, pilot_hit, pilot_m;
    logic [1:0]      wr_slot, rd_slot;
    logic            rd_col_ok;
    logic [3:0]      vsum, kmod;
    logic            unused_idx;

    assign unused_idx  = nrs_index_addr[1];
    assign start       = in_valid & sof;
    assign step        = in_valid & ~sof & (state != WAIT_SOF);
    assign last_sample = (sc == SC_LAST) && (sym == SYM_LAST);
    assign complete    = step & (state == CAPTURE) & last_sample;
    assign demap_ready = bank_full[rd_ptr];
    assign ack_ok      = est_ack_demap & demap_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_SOF;
        else     state <= state_nxt;
    end

    // sof restarts from any state; the FULL check uses the registered bank flags
    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = bank_full[wr_ptr] ? DROP : CAPTURE;
        else if (step && last_sample)
            state_nxt = WAIT_SOF;
    end

    always_comb begin
        is_nrs_sym = 1'b0;
        v3         = 1'b0;
        wr_slot    = 2'd0;
        case (sym)
            SYW'(5):  begin is_nrs_sym = 1'b1; wr_slot = 2'd0; end
            SYW'(6):  begin is_nrs_sym = 1'b1; wr_slot = 2'd1; v3 = 1'b1; end
            SYW'(12): begin is_nrs_sym = 1'b1; wr_slot = 2'd2; end
            SYW'(13): begin is_nrs_sym = 1'b1; wr_slot = 2'd3; v3 = 1'b1; end
            default: ;
        endcase
    end

    assign vsum      = {1'b0, vs_lat} + (v3 ? 4'd3 : 4'd0);
    assign kmod      = (vsum >= 4'd6) ? vsum - 4'd6 : vsum;
    assign pilot_m   = (sc == SCW'(kmod + 4'd6));
    assign pilot_hit = is_nrs_sym & ((sc == SCW'(kmod)) | pilot_m);

    always_comb begin
        bank_full_nxt = bank_full;
        if (complete) bank_full_nxt[wr_ptr] = 1'b1;
        if (ack_ok)   bank_full_nxt[rd_ptr] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc        <= '0;
            sym       <= '0;
            vs_lat    <= '0;
            bank_full <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            bank_full <= bank_full_nxt;
            if (complete) wr_ptr <= ~wr_ptr;
            if (ack_ok)   rd_ptr <= ~rd_ptr;
            if (start) begin
                // the sof sample itself is (0,0), so the next one is subcarrier 1
                vs_lat <= v_shift;
                sc     <= SCW'(1);
                sym    <= '0;
                if (bank_full[wr_ptr]) overflow <= 1'b1;
            end else if (step) begin
                if (sc == SC_LAST) begin
                    sc  <= '0;
                    sym <= last_sample ? '0 : sym + 1'b1;
                end else begin
                    sc <= sc + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (step && (state == CAPTURE) && pilot_hit)
            mem[{wr_ptr, wr_slot, pilot_m}] <= {in_re, in_im};
    end

    always_comb begin
        rd_col_ok = 1'b1;
        rd_slot   = 2'd0;
        case (col)
            4'd5:    rd_slot = 2'd0;
            4'd6:    rd_slot = 2'd1;
            4'd12:   rd_slot = 2'd2;
            4'd13:   rd_slot = 2'd3;
            default: rd_col_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_re    <= '0;
            rd_im    <= '0;
        end else if (demap_read && demap_ready) begin
            rd_valid <= 1'b1;
            if (rd_col_ok) {rd_re, rd_im} <= mem[{rd_ptr, rd_slot, nrs_index_addr[0]}];
            else           {rd_re, rd_im} <= '0;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nrs_demapper.sv
// Directed self-checking bench for nrs_demapper: capture, v_shift, ping-pong, overflow,
// early sof, input gaps and mid-capture reset.
module tb_nrs_demapper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sof = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_re = '0;
    logic [15:0] in_im = '0;
    logic [2:0]  v_shift = '0;
    logic [3:0]  col = '0;
    logic [1:0]  nrs_index_addr = '0;
    logic        demap_read = 1'b0;
    logic        est_ack_demap = 1'b0;
    logic        demap_ready;
    logic [15:0] rd_re, rd_im;
    logic        rd_valid;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nrs_demapper #(.DW(16), .NSC(12), .NSYM(14)) dut (
        .clk(clk), .rst(rst), .sof(sof), .in_valid(in_valid),
        .in_re(in_re), .in_im(in_im), .v_shift(v_shift),
        .col(col), .nrs_index_addr(nrs_index_addr),
        .demap_read(demap_read), .est_ack_demap(est_ack_demap),
        .demap_ready(demap_ready), .rd_re(rd_re), .rd_im(rd_im),
        .rd_valid(rd_valid), .overflow(overflow)
    );

    function automatic logic [15:0] sval(int tag, int idx);
        return 16'(tag * 256 + (idx / 12) * 16 + idx % 12);
    endfunction

    function automatic logic [15:0] model_re(int tag, int vs, int c, int m);
        int v, k;
        v = (c == 6 || c == 13) ? 3 : 0;
        k = (v + vs) % 6 + 6 * m;
        return sval(tag, c * 12 + k);
    endfunction

    // v_shift carries a decoy value except on the sof sample
    task automatic send_samples(int tag, int vs, int gap, int first, int count);
        for (int i = first; i < first + count; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            sof      = (i == 0);
            v_shift  = (i == 0) ? 3'(vs) : 3'(7 - vs);
            in_re    = sval(tag, i);
            in_im    = sval(tag, i) ^ 16'hA5A5;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                sof      = 1'b0;
                in_re    = 16'hDEAD;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    task automatic do_read(int c, int idx, output logic v, output logic [15:0] re, output logic [15:0] im);
        @(negedge clk);
        demap_read     = 1'b1;
        col            = 4'(c);
        nrs_index_addr = 2'(idx);
        @(negedge clk);
        demap_read = 1'b0;
        v  = rd_valid;
        re = rd_re;
        im = rd_im;
    endtask

    task automatic do_ack();
        @(negedge clk);
        est_ack_demap = 1'b1;
        @(negedge clk);
        est_ack_demap = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (demap_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", demap_ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        checks++; if (rd_re !== 16'd0) begin errors++; $display("FAIL reset_rd_re got %0d want 0", rd_re); end
        checks++; if (rd_im !== 16'd0) begin errors++; $display("FAIL reset_rd_im got %0d want 0", rd_im); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    endtask

    task automatic test_basic();
        int cols[8] = '{5, 5, 6, 6, 12, 12, 13, 13};
        logic [15:0] exp_v[8] = '{16'd80, 16'd86, 16'd99, 16'd105, 16'd192, 16'd198, 16'd211, 16'd217};
        logic v;
        logic [15:0] re, im;
        send_samples(0, 0, 0, 0, 167);
        checks++; if (demap_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_early got %b want 0", demap_ready); end
        send_samples(0, 0, 0, 167, 1);
        checks++; if (demap_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", demap_ready); end
        for (int i = 0; i < 8; i++) begin
            do_read(cols[i], i % 2, v, re, im);
            checks++; if (v !== 1'b1) begin errors++; $display("FAIL basic_valid col%0d m%0d got %b want 1", cols[i], i % 2, v); end
            checks++; if (re !== exp_v[i]) begin errors++; $display("FAIL basic_re col%0d m%0d got %0d want %0d", cols[i], i % 2, re, exp_v[i]); end
            checks++; if (im !== (exp_v[i] ^ 16'hA5A5)) begin errors++; $display("FAIL basic_im col%0d m%0d got %h want %h", cols[i], i % 2, im, exp_v[i] ^ 16'hA5A5); end
        end
        @(negedge clk);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", rd_valid); end
        checks++; if (rd_re !== 16'd217) begin errors++; $display("FAIL idle_hold got %0d want 217", rd_re); end
        do_read(7, 0, v, re, im);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL badcol_valid got %b want 1", v); end
        checks++; if ({re, im} !== 32'd0) begin errors++; $display("FAIL badcol_data got %h want 0", {re, im}); end
        do_read(12, 3, v, re, im);
        checks++; if (re !== 16'd198) begin errors++; $display("FAIL idx_bit1 got %0d want 198", re); end
        do_ack();
        checks++; if (demap_ready !== 1'b0) begin errors++; $display("FAIL basic_ack_ready got %b want 0", demap_ready); end
        do_read(5, 0, v, re, im);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL read_not_ready got %b want 0", v); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow got %b want 0", overflow); end
    endtask

    task automatic test_vshift();
        int cols[8] = '{5, 5, 6, 6, 12, 12, 13, 13};
        logic v;
        logic [15:0] re, im, e;
        for (int vs = 0; vs < 6; vs++) begin
            send_samples(vs + 1, vs, 0, 0, 168);
            for (int i = 0; i < 8; i++) begin
                e = model_re(vs + 1, vs, cols[i], i % 2);
                do_read(cols[i], i % 2, v, re, im);
                checks++; if (re !== e) begin errors++; $display("FAIL vshift%0d_col%0d_m%0d got %0d want %0d", vs, cols[i], i % 2, re, e); end
            end
            do_ack();
            checks++; if (demap_ready !== 1'b0) begin errors++; $display("FAIL vshift%0d_ready got %b want 0", vs, demap_ready); end
        end
        // hand value: v_shift=4 -> col5 subcarrier 10, col6 subcarrier 1
        send_samples(0, 4, 0, 0, 168);
        do_read(5, 1, v, re, im);
        checks++; if (re !== 16'd90) begin errors++; $display("FAIL vs4_col5 got %0d want 90", re); end
        do_read(6, 0, v, re, im);
        checks++; if (re !== 16'd97) begin errors++; $display("FAIL vs4_col6 got %0d want 97", re); end
        do_ack();
    endtask

    task automatic test_ping_pong();
        logic v;
        logic [15:0] re, im, e;
        send_samples(10, 1, 0, 0, 168);
        send_samples(11, 2, 0, 0, 168);
        checks++; if (demap_ready !== 1'b1) begin errors++; $display("FAIL pp_ready got %b want 1", demap_ready); end
        e = model_re(10, 1, 6, 1);
        do_read(6, 1, v, re, im);
        checks++; if (re !== e) begin errors++; $display("FAIL pp_first got %0d want %0d", re, e); end
        do_ack();
        checks++; if (demap_ready !== 1'b1) begin errors++; $display("FAIL pp_ready_after_ack got %b want 1", demap_ready); end
        e = model_re(11, 2, 13, 0);
        do_read(13, 0, v, re, im);
        checks++; if (re !== e) begin errors++; $display("FAIL pp_second got %0d want %0d", re, e); end
        do_ack();
        checks++; if (demap_ready !== 1'b0) begin errors++; $display("FAIL pp_ready_final got %b want 0", demap_ready); end
        do_ack();
        checks++; if (demap_ready !== 1'b0) begin errors++; $display("FAIL pp_stray_ack got %b want 0", demap_ready); end
    endtask

    task automatic test_overflow();
        logic v;
        logic [15:0] re, im, e;
        send_samples(20, 0, 0, 0, 168);
        send_samples(21, 3, 0, 0, 168);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
        send_samples(22, 5, 0, 0, 168);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
        e = model_re(20, 0, 5, 0);
        do_read(5, 0, v, re, im);
        checks++; if (re !== e) begin errors++; $display("FAIL ovf_bank_a got %0d want %0d", re, e); end
        do_ack();
        e = model_re(21, 3, 12, 1);
        do_read(12, 1, v, re, im);
        checks++; if (re !== e) begin errors++; $display("FAIL ovf_bank_b got %0d want %0d", re, e); end
        send_samples(23, 4, 0, 0, 168);
        do_ack();
        e = model_re(23, 4, 6, 0);
        do_read(6, 0, v, re, im);
        checks++; if (re !== e) begin errors++; $display("FAIL ovf_fourth got %0d want %0d", re, e); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        do_ack();
    endtask

    task automatic test_early_sof();
        int cols[8] = '{5, 5, 6, 6, 12, 12, 13, 13};
        logic v;
        logic [15:0] re, im, e;
        send_samples(30, 5, 0, 0, 60);
        send_samples(31, 1, 0, 0, 167);
        checks++; if (demap_ready !== 1'b0) begin errors++; $display("FAIL early_ready_soon got %b want 0", demap_ready); end
        send_samples(31, 1, 0, 167, 1);
        checks++; if (demap_ready !== 1'b1) begin errors++; $display("FAIL early_ready got %b want 1", demap_ready); end
        for (int i = 0; i < 8; i++) begin
            e = model_re(31, 1, cols[i], i % 2);
            do_read(cols[i], i % 2, v, re, im);
            checks++; if (re !== e) begin errors++; $display("FAIL early_col%0d_m%0d got %0d want %0d", cols[i], i % 2, re, e); end
        end
        do_ack();
        send_samples(32, 2, 3, 0, 168);
        checks++; if (demap_ready !== 1'b1) begin errors++; $display("FAIL gap_ready got %b want 1", demap_ready); end
        for (int i = 0; i < 8; i++) begin
            e = model_re(32, 2, cols[i], i % 2);
            do_read(cols[i], i % 2, v, re, im);
            checks++; if (re !== e) begin errors++; $display("FAIL gap_col%0d_m%0d got %0d want %0d", cols[i], i % 2, re, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic v;
        logic [15:0] re, im, e;
        // bank from the gap test stays FULL and overflow is still set going in
        send_samples(40, 0, 0, 0, 148);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (demap_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b want 0", demap_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow got %b want 0", overflow); end
        checks++; if ({rd_valid, rd_re, rd_im} !== 33'd0) begin errors++; $display("FAIL rstmid_rd got %h want 0", {rd_valid, rd_re, rd_im}); end
        do_read(5, 0, v, re, im);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL rstmid_read got %b want 0", v); end
        send_samples(41, 3, 0, 0, 168);
        checks++; if (demap_ready !== 1'b1) begin errors++; $display("FAIL rstmid_recap_ready got %b want 1", demap_ready); end
        e = model_re(41, 3, 13, 1);
        do_read(13, 1, v, re, im);
        checks++; if (re !== e) begin errors++; $display("FAIL rstmid_recap got %0d want %0d", re, e); end
        do_ack();
        checks++; if (demap_ready !== 1'b0) begin errors++; $display("FAIL rstmid_single_bank got %b want 0", demap_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vshift();
        test_ping_pong();
        test_overflow();
        test_early_sof();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
